alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Anti-theft sequencing FSM that drives the 1 Hz/2 Hz countdown timer of the automotive alarm system.
- Selects which delay interval to load, pulses the timer's start, and consumes its expired flag.
- Drives siren and status LED outputs.
- Holds a 4-entry programmable table of delay values.
- Sits between the debounced/synchronized vehicle inputs and the timer.

Parameters:
- T_ARM_DEFAULT, 6, reset value of arm delay (s)
- T_DRIVER_DEFAULT, 8, reset value of driver-door delay (s)
- T_PASSENGER_DEFAULT, 15, reset value of passenger-door delay (s)
- T_ALARM_DEFAULT, 10, reset value of siren hold time (s)

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- ignition  in  1  ignition on; synchronized
- driver_door  in  1  1 = driver door open
- passenger_door  in  1  1 = passenger door open
- reprogram  in  1  one-cycle pulse; writes param_value into table[param_sel]
- param_sel  in  2  0=ARM, 1=DRIVER, 2=PASSENGER, 3=ALARM
- param_value  in  4  new delay, seconds
- expired  in  1  timer expired flag
- two_hz_enable  in  1  timer 2 Hz pulse
- start_timer  out  1  one-cycle load pulse to timer
- timer_value  out  4  interval to timer
- siren  out  1  siren drive
- status_led  out  1  status indicator
- state_code  out  3  current state, for debug

Behaviour:
- Reset (sync, one edge):
  - state=DISARMED.
  - start_timer=0, timer_value=0, siren=0, status_led=0, state_code=0.
  - Table restored to the four defaults.
- All outputs are registered.
- Priority within a cycle: reset > reprogram > ignition > door/expired.
- reprogram:
  - Writes table[param_sel] at that edge and forces state=ARMED.
  - Does not pulse start_timer.
  - Value 0 is legal; it causes expiry about 2 cycles after load.
- States and transitions:
  - DISARMED: ignition=0 -> WAIT_OPEN.
  - WAIT_OPEN: ignition -> DISARMED; driver_door -> WAIT_CLOSE.
  - WAIT_CLOSE: ignition -> DISARMED; both doors closed -> ARM_DELAY, load ARM.
  - ARM_DELAY: ignition -> DISARMED; any door open -> WAIT_CLOSE; expired -> ARMED.
  - ARMED: ignition -> DISARMED; driver_door -> TRIGGERED, load DRIVER; else passenger_door -> TRIGGERED, load PASSENGER. Driver wins if both doors open together.
  - TRIGGERED: ignition -> DISARMED; expired -> ALARM.
  - ALARM: ignition -> DISARMED; both doors closed -> SIREN_HOLD, load ALARM.
  - SIREN_HOLD: ignition -> DISARMED; any door open -> ALARM (no load); expired -> ARMED.
- Load protocol:
  - On the edge that enters a loading state, start_timer<=1 and timer_value<=table[sel].
  - start_timer drops the following edge.
  - timer_value holds its last loaded value until the next load.
- Stale-expiry rule:
  - While start_timer=1, expired is stale and is ignored.
  - In any state, expired is acted on only when start_timer=0.
- Outputs per state:
  - siren=1 in ALARM and SIREN_HOLD, 0 elsewhere.
  - status_led=0 in DISARMED, WAIT_OPEN, WAIT_CLOSE, ARM_DELAY.
  - status_led=1 solid in TRIGGERED, ALARM, SIREN_HOLD.
  - In ARMED, status_led toggles on each two_hz_enable pulse and starts at 0 on entry.
- state_code encoding: DISARMED=0, WAIT_OPEN=1, WAIT_CLOSE=2, ARM_DELAY=3, ARMED=4, TRIGGERED=5, ALARM=6, SIREN_HOLD=7.
- Illegal/unreached encodings go to DISARMED.

Decomposition:
- Shared package alarm_pkg holds:
  - state enum and state_code values
  - param_sel codes (SEL_ARM..SEL_ALARM)
  - default delay constants
- One sub-module: alarm_param_table.
  - 4x4-bit register file, synchronous write on reprogram, combinational read by sel, reset to defaults.
- The FSM stays in alarm_controller.

Test Plan:
- Reset mid-operation: reset while in ALARM -> next edge state_code=0, siren=0, status_led=0, start_timer=0, and table reads back 6/8/15/10.
- Arming sequence, with the real timer bench-scaled to ONE_HZ_MAX=4: ignition 1->0, driver_door 1 then 0 -> single start_timer pulse with timer_value=6; after 6 one-second ticks plus expiry -> ARMED (4).
- Passenger trigger: in ARMED, passenger_door=1 -> TRIGGERED with timer_value=15, status_led=1; on expiry -> ALARM, siren=1. Close doors -> SIREN_HOLD with timer_value=10; on expiry -> ARMED, siren=0.
- Simultaneous doors and ignition:
  - driver_door and passenger_door rise in the same cycle in ARMED -> timer_value=8.
  - ignition=1 in TRIGGERED -> DISARMED, siren never asserted.
- Stale expiry: expired held 1 from the prior interval while start_timer=1 on entering TRIGGERED -> state stays TRIGGERED that cycle.
- Reprogram: reprogram, param_sel=1, param_value=3 -> state ARMED, no start_timer; a driver door then loads timer_value=3. Same-cycle reprogram and ignition -> ARMED.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the anti-theft alarm controller: FSM state encoding
// (which doubles as the debug state_code), delay-table selector codes and the
// reset values of the delay table.
package alarm_pkg;

  typedef enum logic [2:0] {
    StDisarmed  = 3'd0,
    StWaitOpen  = 3'd1,
    StWaitClose = 3'd2,
    StArmDelay  = 3'd3,
    StArmed     = 3'd4,
    StTriggered = 3'd5,
    StAlarm     = 3'd6,
    StSirenHold = 3'd7
  } alarm_state_e;

  // Delay-table selectors
  localparam logic [1:0] SEL_ARM       = 2'd0;
  localparam logic [1:0] SEL_DRIVER    = 2'd1;
  localparam logic [1:0] SEL_PASSENGER = 2'd2;
  localparam logic [1:0] SEL_ALARM     = 2'd3;

  // Reset contents of the delay table, in seconds
  localparam logic [3:0] DEFAULT_ARM       = 4'd6;
  localparam logic [3:0] DEFAULT_DRIVER    = 4'd8;
  localparam logic [3:0] DEFAULT_PASSENGER = 4'd15;
  localparam logic [3:0] DEFAULT_ALARM     = 4'd10;

endpackage

// File: rtl/alarm_param_table.sv
// Four-entry table of 4-bit delay values (seconds) used by the alarm FSM.
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   write_en                - write strobe (the reprogram pulse)
//   write_sel, write_value  - entry to overwrite and its new value
//   read_sel                - entry to read
//   read_value              - combinational read data
// Reset restores all four entries to their parameterised defaults.
module alarm_param_table
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DEFAULT       = DEFAULT_ARM,
  parameter logic [3:0] T_DRIVER_DEFAULT    = DEFAULT_DRIVER,
  parameter logic [3:0] T_PASSENGER_DEFAULT = DEFAULT_PASSENGER,
  parameter logic [3:0] T_ALARM_DEFAULT     = DEFAULT_ALARM
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_en,
  input  logic [1:0] write_sel,
  input  logic [3:0] write_value,
  input  logic [1:0] read_sel,
  output logic [3:0] read_value
);

  logic [3:0] delay_q [4];

  always_ff @(posedge clock) begin
    if (reset) begin
      delay_q[SEL_ARM]       <= T_ARM_DEFAULT;
      delay_q[SEL_DRIVER]    <= T_DRIVER_DEFAULT;
      delay_q[SEL_PASSENGER] <= T_PASSENGER_DEFAULT;
      delay_q[SEL_ALARM]     <= T_ALARM_DEFAULT;
    end else if (write_en) begin
      delay_q[write_sel] <= write_value;
    end
  end

  assign read_value = delay_q[read_sel];

endmodule

// File: rtl/alarm_controller.sv
// Anti-theft sequencing FSM. Chooses which delay to load into the external
// countdown timer, pulses start_timer for one cycle on each load, reacts to the
// timer's expired flag, and drives the siren and status LED.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   ignition            - ignition on (synchronised)
//   driver_door         - 1 = driver door open
//   passenger_door      - 1 = passenger door open
//   reprogram           - one-cycle pulse: table[param_sel] <= param_value, go ARMED
//   param_sel           - table entry to reprogram (ARM/DRIVER/PASSENGER/ALARM)
//   param_value         - new delay, seconds
//   expired             - timer expired flag
//   two_hz_enable       - timer 2 Hz pulse, blinks the LED while armed
//   start_timer         - one-cycle load pulse to the timer
//   timer_value         - interval presented to the timer (held between loads)
//   siren               - siren drive
//   status_led          - status indicator
//   state_code          - current FSM state, for debug
// All outputs are registered.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DEFAULT       = DEFAULT_ARM,
  parameter logic [3:0] T_DRIVER_DEFAULT    = DEFAULT_DRIVER,
  parameter logic [3:0] T_PASSENGER_DEFAULT = DEFAULT_PASSENGER,
  parameter logic [3:0] T_ALARM_DEFAULT     = DEFAULT_ALARM
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       reprogram,
  input  logic [1:0] param_sel,
  input  logic [3:0] param_value,
  input  logic       expired,
  input  logic       two_hz_enable,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state_code
);

  alarm_state_e state_q, state_d;
  logic         start_q, start_d;
  logic [3:0]   value_q, value_d;
  logic         siren_q, siren_d;
  logic         led_q, led_d;

  logic         load;
  logic [1:0]   load_sel;
  logic [3:0]   table_value;
  logic         door_open;
  logic         expired_fresh;

  alarm_param_table #(
    .T_ARM_DEFAULT       (T_ARM_DEFAULT),
    .T_DRIVER_DEFAULT    (T_DRIVER_DEFAULT),
    .T_PASSENGER_DEFAULT (T_PASSENGER_DEFAULT),
    .T_ALARM_DEFAULT     (T_ALARM_DEFAULT)
  ) u_param_table (
    .clock       (clock),
    .reset       (reset),
    .write_en    (reprogram),
    .write_sel   (param_sel),
    .write_value (param_value),
    .read_sel    (load_sel),
    .read_value  (table_value)
  );

  assign door_open = driver_door | passenger_door;
  // While a load pulse is outstanding the timer has not yet reloaded, so its
  // expired flag still refers to the previous interval.
  assign expired_fresh = expired & ~start_q;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_sel = SEL_ARM;

    if (reprogram) begin
      state_d = StArmed;
    end else if (ignition) begin
      state_d = StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed:  state_d = StWaitOpen;
        StWaitOpen:  if (driver_door) state_d = StWaitClose;
        StWaitClose: begin
          if (!door_open) begin
            state_d  = StArmDelay;
            load     = 1'b1;
            load_sel = SEL_ARM;
          end
        end
        StArmDelay: begin
          if (door_open)          state_d = StWaitClose;
          else if (expired_fresh) state_d = StArmed;
        end
        StArmed: begin
          // Driver door takes precedence when both open together
          if (driver_door) begin
            state_d  = StTriggered;
            load     = 1'b1;
            load_sel = SEL_DRIVER;
          end else if (passenger_door) begin
            state_d  = StTriggered;
            load     = 1'b1;
            load_sel = SEL_PASSENGER;
          end
        end
        StTriggered: if (expired_fresh) state_d = StAlarm;
        StAlarm: begin
          if (!door_open) begin
            state_d  = StSirenHold;
            load     = 1'b1;
            load_sel = SEL_ALARM;
          end
        end
        StSirenHold: begin
          if (door_open)          state_d = StAlarm;
          else if (expired_fresh) state_d = StArmed;
        end
        default: state_d = StDisarmed;
      endcase
    end
  end

  always_comb begin
    start_d = load;
    value_d = load ? table_value : value_q;
    siren_d = (state_d == StAlarm) || (state_d == StSirenHold);

    led_d = 1'b0;
    if (state_d == StArmed) begin
      // Blink phase restarts at 0 on every entry into ARMED
      led_d = (state_q == StArmed) ? (led_q ^ two_hz_enable) : 1'b0;
    end else if ((state_d == StTriggered) || (state_d == StAlarm) ||
                 (state_d == StSirenHold)) begin
      led_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StDisarmed;
      start_q <= 1'b0;
      value_q <= 4'd0;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      value_q <= value_d;
      siren_q <= siren_d;
      led_q   <= led_d;
    end
  end

  assign start_timer = start_q;
  assign timer_value = value_q;
  assign siren       = siren_q;
  assign status_led  = led_q;
  assign state_code  = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

  localparam int ONE_HZ_MAX = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition;
  logic       driver_door;
  logic       passenger_door;
  logic       reprogram;
  logic [1:0] param_sel;
  logic [3:0] param_value;
  logic       expired;
  logic       two_hz_enable;
  logic       start_timer;
  logic [3:0] timer_value;
  logic       siren;
  logic       status_led;
  logic [2:0] state_code;

  int checks = 0;
  int errors = 0;

  alarm_controller dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .driver_door    (driver_door),
    .passenger_door (passenger_door),
    .reprogram      (reprogram),
    .param_sel      (param_sel),
    .param_value    (param_value),
    .expired        (expired),
    .two_hz_enable  (two_hz_enable),
    .start_timer    (start_timer),
    .timer_value    (timer_value),
    .siren          (siren),
    .status_led     (status_led),
    .state_code     (state_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Countdown timer stand-in: reloads on the edge after it sees start_timer,
  // counts seconds of ONE_HZ_MAX cycles, then holds expired until next load.
  bit use_timer = 1'b0;
  int tmr_cnt = 0, tmr_div = 0, tmr_ldv = 0;
  bit tmr_exp = 1'b0, tmr_ld = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
    if (use_timer) begin
      if (tmr_ld) begin
        tmr_cnt = tmr_ldv;
        tmr_div = 0;
        tmr_exp = 1'b0;
      end else if (!tmr_exp) begin
        if (tmr_cnt == 0) tmr_exp = 1'b1;
        else begin
          tmr_div++;
          if (tmr_div == ONE_HZ_MAX) begin
            tmr_div = 0;
            tmr_cnt--;
          end
        end
      end
      tmr_ld  = start_timer;
      tmr_ldv = int'(timer_value);
      expired = tmr_exp;
    end
  endtask

  // Reference model: states as plain integers 0..7, delays in an int array.
  int m_st, m_tv;
  bit m_start, m_led;
  int m_tab [4];

  function automatic void model_reset();
    m_st = 0; m_tv = 0; m_start = 0; m_led = 0;
    m_tab[0] = 6; m_tab[1] = 8; m_tab[2] = 15; m_tab[3] = 10;
  endfunction

  function automatic void model_step();
    int nx = m_st;
    int ld = -1;
    bit open  = driver_door | passenger_door;
    bit fresh = expired && !m_start;
    if (reprogram) begin
      m_tab[param_sel] = int'(param_value);
      nx = 4;
    end else if (ignition) begin
      nx = 0;
    end else begin
      case (m_st)
        0: nx = 1;
        1: if (driver_door) nx = 2;
        2: if (!open) begin nx = 3; ld = 0; end
        3: if (open) nx = 2; else if (fresh) nx = 4;
        4: if (driver_door) begin nx = 5; ld = 1; end
           else if (passenger_door) begin nx = 5; ld = 2; end
        5: if (fresh) nx = 6;
        6: if (!open) begin nx = 7; ld = 3; end
        7: if (open) nx = 6; else if (fresh) nx = 4;
        default: nx = 0;
      endcase
    end
    m_start = (ld >= 0);
    if (ld >= 0) m_tv = m_tab[ld];
    if (nx == 4) m_led = (m_st == 4) ? (m_led ^ two_hz_enable) : 1'b0;
    else m_led = (nx >= 5);
    m_st = nx;
  endfunction

  typedef struct {
    bit ign, drv, pas, rp;
    bit [1:0] sel;
    bit [3:0] val;
    bit ex, hz;
    bit [2:0] st;
    bit start;
    bit [3:0] tv;
    bit sir, led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit ign, bit drv, bit pas, bit rp, bit [1:0] sel, bit [3:0] val,
                              bit ex, bit hz, bit [2:0] st, bit start, bit [3:0] tv, bit sir,
                              bit led);
    vec_t v;
    v.ign = ign; v.drv = drv; v.pas = pas; v.rp = rp; v.sel = sel; v.val = val;
    v.ex = ex; v.hz = hz; v.st = st; v.start = start; v.tv = tv; v.sir = sir; v.led = led;
    return v;
  endfunction

  task automatic clear_inputs();
    ignition = 0; driver_door = 0; passenger_door = 0; reprogram = 0;
    param_sel = 0; param_value = 0; expired = 0; two_hz_enable = 0;
  endtask

  int  pulses, last_tv;
  bit  found;

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    check("reset_state", state_code, 0);
    check("reset_start", start_timer, 0);
    check("reset_tv", timer_value, 0);
    check("reset_siren", siren, 0);
    check("reset_led", status_led, 0);
    reset = 1'b0;

    //          ign drv pas rp sel val ex hz | st s tv sir led
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 6,  0, 0)); // stale expiry
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 6,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 6,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 6,  0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 5, 1, 8,  0, 1)); // driver wins
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 8,  0, 1)); // stale expiry
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 8,  1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 6, 0, 8,  1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 10, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 6, 0, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 10, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 3, 0, 0, 4, 0, 10, 0, 0)); // reprogram beats ignition
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 3,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 4, 0, 3,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0,  0, 1)); // zero delay loads
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0,  1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      ignition = vecs[i].ign; driver_door = vecs[i].drv; passenger_door = vecs[i].pas;
      reprogram = vecs[i].rp; param_sel = vecs[i].sel; param_value = vecs[i].val;
      expired = vecs[i].ex; two_hz_enable = vecs[i].hz;
      tick();
      check($sformatf("vec%0d_state", i), state_code, vecs[i].st);
      check($sformatf("vec%0d_start", i), start_timer, vecs[i].start);
      check($sformatf("vec%0d_tv", i), timer_value, vecs[i].tv);
      check($sformatf("vec%0d_siren", i), siren, vecs[i].sir);
      check($sformatf("vec%0d_led", i), status_led, vecs[i].led);
    end

    // Reset while in ALARM
    clear_inputs();
    reset = 1'b1;
    tick();
    check("midreset_state", state_code, 0);
    check("midreset_siren", siren, 0);
    check("midreset_led", status_led, 0);
    check("midreset_start", start_timer, 0);
    check("midreset_tv", timer_value, 0);
    reset = 1'b0;

    // Arming sequence with the timer stand-in; loads also show defaults restored
    use_timer = 1'b1; tmr_cnt = 0; tmr_div = 0; tmr_exp = 0; tmr_ld = 0;
    ignition = 1; tick();
    ignition = 0; tick();
    driver_door = 1; tick();
    check("arm_waitclose", state_code, 2);
    driver_door = 0;
    pulses = 0; last_tv = 0; found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (start_timer) begin pulses++; last_tv = int'(timer_value); end
      if (state_code == 4) found = 1;
    end
    check("arm_reached", state_code, 4);
    check("arm_pulses", pulses, 1);
    check("arm_tv", last_tv, 6);

    // Passenger trigger through to siren hold and back to armed
    passenger_door = 1; tick();
    check("pas_state", state_code, 5);
    check("pas_tv", timer_value, 15);
    check("pas_start", start_timer, 1);
    check("pas_led", status_led, 1);
    passenger_door = 0; tick();
    check("stale_trig_state", state_code, 5);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (state_code == 6) found = 1;
    end
    check("alarm_reached", state_code, 6);
    check("alarm_siren", siren, 1);
    tick();
    check("hold_state", state_code, 7);
    check("hold_tv", timer_value, 10);
    check("hold_start", start_timer, 1);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (state_code == 4) found = 1;
    end
    check("rearm_reached", state_code, 4);
    check("rearm_siren", siren, 0);

    // Both doors together, then ignition in TRIGGERED
    driver_door = 1; passenger_door = 1; tick();
    check("both_state", state_code, 5);
    check("both_tv", timer_value, 8);
    driver_door = 0; passenger_door = 0; ignition = 1; tick();
    check("ign_trig_state", state_code, 0);
    check("ign_trig_siren", siren, 0);
    ignition = 0;
    use_timer = 1'b0;

    // Randomised run against the reference model
    clear_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      ignition       = ($urandom_range(0, 7) == 0);
      driver_door    = ($urandom_range(0, 2) == 0);
      passenger_door = ($urandom_range(0, 2) == 0);
      reprogram      = ($urandom_range(0, 31) == 0);
      param_sel      = 2'($urandom_range(0, 3));
      param_value    = 4'($urandom_range(0, 15));
      expired        = ($urandom_range(0, 2) == 0);
      two_hz_enable  = ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 255) == 0);
      if (reset) model_reset();
      else model_step();
      tick();
      check("rand_state", state_code, m_st);
      check("rand_start", start_timer, m_start);
      check("rand_tv", timer_value, m_tv);
      check("rand_siren", siren, (m_st >= 6));
      check("rand_led", status_led, m_led);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
